// File: rtl/axi_uart_master.sv
// AXI4-Lite single-outstanding initiator for the load/store unit; zero-wait slave gives rsp_valid_o 4 cycles after accept.
// Holds every valid until its handshake (req_ready_o low while busy); AXI_MASTER_TIMEOUT_EN aborts a stalled transaction.
`timescale 1ns/1ps
module axi_uart_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              m_axi_aclk_i,
  input  logic              m_axi_areset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_strb_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] m_axi_araddr_o,
  output logic              m_axi_arvalid_o,
  input  logic              m_axi_arready_i,
  input  logic [31:0]       m_axi_rdata_i,
  input  logic [1:0]        m_axi_rresp_i,
  input  logic              m_axi_rvalid_i,
  output logic              m_axi_rready_o,
  output logic [ADDR_W-1:0] m_axi_awaddr_o,
  output logic              m_axi_awvalid_o,
  input  logic              m_axi_awready_i,
  output logic [31:0]       m_axi_wdata_o,
  output logic [3:0]        m_axi_wstrb_o,
  output logic              m_axi_wvalid_o,
  input  logic              m_axi_wready_i,
  input  logic [1:0]        m_axi_bresp_i,
  input  logic              m_axi_bvalid_i,
  output logic              m_axi_bready_o,
  output logic [3:0]        read_size_o
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t state;
  logic   aw_left;
  logic   w_left;

  // AW and W retire independently; each stays up only until its own handshake
  assign aw_left = m_axi_awvalid_o & ~m_axi_awready_i;
  assign w_left  = m_axi_wvalid_o  & ~m_axi_wready_i;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             busy;

  assign busy = (state == RD_ADDR) || (state == RD_DATA) ||
                (state == WR_REQ)  || (state == WR_RESP);
`endif

  always_ff @(posedge m_axi_aclk_i) begin
    if (m_axi_areset_i) begin
      state           <= IDLE;
      req_ready_o     <= 1'b1;
      rsp_valid_o     <= 1'b0;
      rsp_rdata_o     <= '0;
      rsp_err_o       <= 1'b0;
      m_axi_araddr_o  <= '0;
      m_axi_arvalid_o <= 1'b0;
      m_axi_rready_o  <= 1'b0;
      m_axi_awaddr_o  <= '0;
      m_axi_awvalid_o <= 1'b0;
      m_axi_wdata_o   <= '0;
      m_axi_wstrb_o   <= '0;
      m_axi_wvalid_o  <= 1'b0;
      m_axi_bready_o  <= 1'b0;
      read_size_o     <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_cnt         <= '0;
`endif
    end else begin
      rsp_valid_o <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      if (busy) tmo_cnt <= tmo_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
            if (req_write_i) begin
              m_axi_awaddr_o  <= req_addr_i;
              m_axi_wdata_o   <= req_wdata_i;
              m_axi_wstrb_o   <= req_strb_i;
              m_axi_awvalid_o <= 1'b1;
              m_axi_wvalid_o  <= 1'b1;
              read_size_o     <= '0;
              state           <= WR_REQ;
            end else begin
              m_axi_araddr_o  <= req_addr_i;
              m_axi_arvalid_o <= 1'b1;
              read_size_o     <= req_strb_i;
              state           <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m_axi_arready_i) begin
            m_axi_arvalid_o <= 1'b0;
            m_axi_rready_o  <= 1'b1;
            state           <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid_i) begin
            m_axi_rready_o <= 1'b0;
            rsp_rdata_o    <= m_axi_rdata_i;
            rsp_err_o      <= (m_axi_rresp_i != 2'b00);
            state          <= DONE;
          end
        end
        WR_REQ: begin
          m_axi_awvalid_o <= aw_left;
          m_axi_wvalid_o  <= w_left;
          if (!aw_left && !w_left) begin
            m_axi_bready_o <= 1'b1;
            state          <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid_i) begin
            m_axi_bready_o <= 1'b0;
            rsp_err_o      <= (m_axi_bresp_i != 2'b00);
            state          <= DONE;
          end
        end
        DONE: begin
          rsp_valid_o <= 1'b1;
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef AXI_MASTER_TIMEOUT_EN
      // Abort overrides whatever the phase logic scheduled this cycle
      if (busy && (tmo_cnt == TMO_LAST)) begin
        m_axi_arvalid_o <= 1'b0;
        m_axi_rready_o  <= 1'b0;
        m_axi_awvalid_o <= 1'b0;
        m_axi_wvalid_o  <= 1'b0;
        m_axi_bready_o  <= 1'b0;
        rsp_err_o       <= 1'b1;
        rsp_rdata_o     <= 32'hDEAD_BEEF;
        state           <= DONE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_uart_master.sv
// Bench for axi_uart_master: negedge-driven AXI slave with per-channel delays, table vectors plus random traffic.
`timescale 1ns/1ps
module tb_axi_uart_master;
  localparam int TMO = 16;
  localparam int CAP = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb, read_size;

  always #5 clk = ~clk;

  axi_uart_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .m_axi_aclk_i(clk), .m_axi_areset_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .m_axi_araddr_o(araddr), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
    .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
    .m_axi_awaddr_o(awaddr), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
    .read_size_o(read_size)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic [1:0]  resp;
    logic [31:0] rdat;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  wstrb, rsize;
    int          rsp_cyc, rsp_cnt;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    int          viol;
    logic        ready_after, arvalid_after;
  } obs_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_rdata = '0;
  logic [143:0] exp_rst;

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%036h, expected 0x%036h", nm, act, exp);
    end
  endtask

  function automatic logic [143:0] outs();
    return {req_ready, rsp_valid, rsp_rdata, rsp_err, araddr, arvalid, rready,
            awaddr, awvalid, wdata, wstrb, wvalid, bready, read_size};
  endfunction

  function automatic int exp_latency(input vec_t v);
    int m;
    m = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
    return v.wr ? (4 + m + v.b_dly) : (4 + v.ar_dly + v.r_dly);
  endfunction

  task automatic slave_idle();
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0;
  endtask

  // Issue one request at the current negedge and play the slave until one cycle after the response.
  task automatic run_txn(input vec_t v, output obs_t o);
    logic ar_done, r_done, aw_done, w_done, b_done, ar_prev, aw_prev, w_prev;
    int   ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0;
    ar_prev = 0; aw_prev = 0; w_prev = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    o = '{default: 0};
    o.rsp_cyc = -1;
    req_valid = 1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdat; req_strb = v.strb;
    @(negedge clk);
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_strb = '0;
    for (int cyc = 1; cyc <= CAP; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 1) begin
        o.rsize  = read_size;
        o.araddr = araddr;
      end
      rvalid = 0;
      if (ar_done && !r_done) begin
        if (r_cnt >= v.r_dly) begin rvalid = 1; rdata = v.rdat; rresp = v.resp; end
        r_cnt++;
        if (rvalid && rready) begin o.r_hs++; r_done = 1; end
      end
      bvalid = 0;
      if (aw_done && w_done && !b_done) begin
        if (b_cnt >= v.b_dly) begin bvalid = 1; bresp = v.resp; end
        b_cnt++;
        if (bvalid && bready) begin o.b_hs++; b_done = 1; end
      end
      if ((ar_done && arvalid) || (!ar_done && ar_prev && !arvalid)) o.viol++;
      ar_prev = arvalid;
      arready = 0;
      if (arvalid && !ar_done) begin
        if (ar_cnt >= v.ar_dly) begin
          arready = 1; ar_done = 1; o.ar_hs++; o.araddr = araddr; o.rsize = read_size;
        end
        ar_cnt++;
      end
      if ((aw_done && awvalid) || (!aw_done && aw_prev && !awvalid)) o.viol++;
      aw_prev = awvalid;
      awready = 0;
      if (awvalid && !aw_done) begin
        if (aw_cnt >= v.aw_dly) begin awready = 1; aw_done = 1; o.aw_hs++; o.awaddr = awaddr; end
        aw_cnt++;
      end
      if ((w_done && wvalid) || (!w_done && w_prev && !wvalid)) o.viol++;
      w_prev = wvalid;
      wready = 0;
      if (wvalid && !w_done) begin
        if (w_cnt >= v.w_dly) begin
          wready = 1; w_done = 1; o.w_hs++; o.wdata = wdata; o.wstrb = wstrb;
        end
        w_cnt++;
      end
      if (rsp_valid) begin
        o.rsp_cnt++;
        if (o.rsp_cyc < 0) begin o.rsp_cyc = cyc; o.rsp_rdata = rsp_rdata; o.rsp_err = rsp_err; end
      end
      if (o.rsp_cyc >= 0 && cyc == o.rsp_cyc + 1) begin
        o.ready_after = req_ready; o.arvalid_after = arvalid;
        break;
      end
    end
    slave_idle();
  endtask

  task automatic verify(input string tag, input vec_t v, input obs_t o, input logic tmo);
    if (tmo) model_rdata = 32'hDEAD_BEEF;
    else if (!v.wr) model_rdata = v.rdat;
    chk_int({tag, ".latency"}, o.rsp_cyc, v.exp_lat);
    chk_int({tag, ".rsp_pulses"}, o.rsp_cnt, 1);
    chk32({tag, ".rsp_err"}, 32'(o.rsp_err), 32'(v.exp_err));
    chk32({tag, ".rsp_rdata"}, o.rsp_rdata, model_rdata);
    chk32({tag, ".read_size"}, 32'(o.rsize), v.wr ? 32'h0 : 32'(v.strb));
    chk32({tag, ".req_ready_after"}, 32'(o.ready_after), 32'h1);
    chk32({tag, ".arvalid_after"}, 32'(o.arvalid_after), 32'h0);
    chk_int({tag, ".valid_rule_breaks"}, o.viol, tmo ? 1 : 0);
    if (v.wr) begin
      chk32({tag, ".awaddr"}, o.awaddr, v.addr);
      chk32({tag, ".wdata"}, o.wdata, v.wdat);
      chk32({tag, ".wstrb"}, 32'(o.wstrb), 32'(v.strb));
      chk_int({tag, ".aw_w_b_handshakes"}, o.aw_hs * 100 + o.w_hs * 10 + o.b_hs, 111);
      chk_int({tag, ".read_handshakes"}, o.ar_hs + o.r_hs, 0);
    end else begin
      chk32({tag, ".araddr"}, o.araddr, v.addr);
      chk_int({tag, ".ar_r_handshakes"}, o.ar_hs * 10 + o.r_hs, tmo ? 0 : 11);
      chk_int({tag, ".write_handshakes"}, o.aw_hs + o.w_hs + o.b_hs, 0);
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    obs_t o;
    int   saw;

    //          wr  addr           wdat           strb  ar r aw w b resp   rdat           err lat
    tbl[0] = '{1'b1, 32'h2000_0000, 32'h0003_0002, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,         1'b0, 4};
    tbl[1] = '{1'b0, 32'h2000_0004, 32'h0,         4'h1, 0, 3, 0, 0, 0, 2'b00, 32'h0000_000A, 1'b0, 7};
    tbl[2] = '{1'b1, 32'h2000_0000, 32'h0000_0041, 4'h1, 0, 0, 2, 0, 0, 2'b00, 32'h0,         1'b0, 6};
    tbl[3] = '{1'b1, 32'h2000_0008, 32'h1234_5678, 4'hC, 0, 0, 0, 2, 0, 2'b00, 32'h0,         1'b0, 6};
    tbl[4] = '{1'b1, 32'h2000_000C, 32'hCAFE_F00D, 4'h3, 0, 0, 1, 1, 0, 2'b00, 32'h0,         1'b0, 5};
    tbl[5] = '{1'b1, 32'h2000_0000, 32'h0000_00FF, 4'hF, 0, 0, 0, 0, 0, 2'b10, 32'h0,         1'b1, 4};
    tbl[6] = '{1'b0, 32'h2000_0004, 32'h0,         4'h3, 0, 0, 0, 0, 0, 2'b11, 32'h0000_0055, 1'b1, 4};
    tbl[7] = '{1'b0, 32'h2000_0010, 32'h0,         4'hF, 2, 1, 0, 0, 0, 2'b00, 32'h8765_4321, 1'b0, 7};

    rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_strb = '0;
    slave_idle();
    exp_rst = '0;
    exp_rst[143] = 1'b1;
    repeat (3) @(negedge clk);
    chk_wide("reset_state", outs(), exp_rst);
    rst = 0;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], o);
      verify($sformatf("vec%0d", i), tbl[i], o, 1'b0);
    end

    // Reset while the write sits in WR_RESP waiting for B
    req_valid = 1; req_write = 1; req_addr = 32'h2000_0008; req_wdata = 32'h0000_0077; req_strb = 4'hF;
    @(negedge clk);
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_strb = '0;
    awready = 1; wready = 1;
    @(negedge clk);
    awready = 0; wready = 0;
    chk32("midrst.bready_before", 32'(bready), 32'h1);
    rst = 1;
    @(negedge clk);
    chk_wide("midrst.outputs", outs(), exp_rst);
    rst = 0;
    model_rdata = '0;
    saw = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) saw++;
    end
    chk_int("midrst.no_rsp", saw, 0);
    v = '{1'b0, 32'h2000_0004, 32'h0, 4'h2, 0, 0, 0, 0, 0, 2'b00, 32'h0000_BEEF, 1'b0, 4};
    run_txn(v, o);
    verify("midrst.next", v, o, 1'b0);

`ifdef AXI_MASTER_TIMEOUT_EN
    v = '{1'b0, 32'h2000_0004, 32'h0, 4'h1, 1000, 0, 0, 0, 0, 2'b00, 32'h0, 1'b1, TMO + 2};
    run_txn(v, o);
    verify("timeout", v, o, 1'b1);
    v = '{1'b0, 32'h2000_0004, 32'h0, 4'h1, 0, 1, 0, 0, 0, 2'b00, 32'h0000_0033, 1'b0, 5};
    run_txn(v, o);
    verify("after_timeout", v, o, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      v.wr     = 1'($urandom_range(0, 1));
      v.addr   = 32'h2000_0000 + 32'($urandom_range(0, 63));
      v.wdat   = $urandom;
      v.strb   = 4'($urandom_range(0, 15));
      v.ar_dly = $urandom_range(0, 3);
      v.r_dly  = $urandom_range(0, 3);
      v.aw_dly = $urandom_range(0, 3);
      v.w_dly  = $urandom_range(0, 3);
      v.b_dly  = $urandom_range(0, 3);
      v.resp   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      v.rdat   = $urandom;
      v.exp_err = (v.resp != 2'b00);
      v.exp_lat = exp_latency(v);
      run_txn(v, o);
      verify($sformatf("rand%0d", i), v, o, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
